// File: rtl/ram_responder.sv
// Data-memory responder for the CPU's ram_read/ram_write interface: a 2^ADDR_W x DATA_W
// word store with a ready/ack handshake, programmable wait states and a post-reset clear.
module ram_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] ram_read_addr,
    input  logic [ADDR_W-1:0] ram_write_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_ready,
    output logic              ram_ack
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [3:0]        wait_q, wait_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, data_in_q, data_in_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req, go_resp;
    logic              eff_rd, eff_wr;
    logic [ADDR_W-1:0] eff_rd_addr, eff_wr_addr;
    logic [DATA_W-1:0] eff_wr_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        req = ram_read | ram_write;
        // With zero wait states the access completes on the acceptance edge, so use the live inputs.
        if (state_q == S_IDLE) begin
            eff_rd      = ram_read;
            eff_wr      = ram_write;
            eff_rd_addr = ram_read_addr;
            eff_wr_addr = ram_write_addr;
            eff_wr_data = ram_data_out;
        end else begin
            eff_rd      = rd_q;
            eff_wr      = wr_q;
            eff_rd_addr = rd_addr_q;
            eff_wr_addr = wr_addr_q;
            eff_wr_data = wr_data_q;
        end
        go_resp = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
                  ((state_q == S_WAIT) && (wait_q == 4'd0));

        state_d   = state_q;
        sweep_d   = sweep_q;
        wait_d    = wait_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        data_in_d = data_in_q;
        mem_we    = 1'b0;
        mem_waddr = eff_wr_addr;
        mem_wdata = eff_wr_data;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + ADDR_W'(1);
                if (sweep_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req) begin
                    rd_d      = ram_read;
                    wr_d      = ram_write;
                    rd_addr_d = ram_read_addr;
                    wr_addr_d = ram_write_addr;
                    wr_data_d = ram_data_out;
                    wait_d    = WAIT_LOAD;
                    state_d   = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_RESP;
                else                wait_d  = wait_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        // Write-before-read: a same-address read sees the data being written.
        if (go_resp) begin
            if (eff_wr) mem_we = 1'b1;
            if (eff_rd) data_in_d = (eff_wr && (eff_wr_addr == eff_rd_addr)) ? eff_wr_data
                                                                              : mem[eff_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            sweep_q   <= '0;
            wait_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            wait_q    <= wait_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            data_in_q <= data_in_d;
        end
    end

    // Storage has no reset; the INIT sweep clears it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    end

    assign ram_data_in = data_in_q;
    assign ram_ready   = (state_q == S_IDLE);
    assign ram_ack     = (state_q == S_RESP);
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (1, 0 and 3 wait states) checked against
// directed vectors, hand-written corner sequences and a word-array reference model.
module tb_ram_responder;
    logic        clk = 1'b0;
    logic        rst [3];
    logic        rd_i [3];
    logic        wr_i [3];
    logic [5:0]  ra_i [3];
    logic [5:0]  wa_i [3];
    logic [15:0] wd_i [3];
    logic [15:0] din [3];
    logic        ready [3];
    logic        ack [3];

    int tests = 0;
    int fails = 0;

    logic [15:0] mdl_mem [3][64];
    logic [15:0] mdl_dout [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WSG = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        ram_responder #(.DATA_W(16), .ADDR_W(6), .WAIT_STATES(WSG)) u_dut (
            .clk           (clk),
            .reset         (rst[g]),
            .ram_read      (rd_i[g]),
            .ram_write     (wr_i[g]),
            .ram_read_addr (ra_i[g]),
            .ram_write_addr(wa_i[g]),
            .ram_data_out  (wd_i[g]),
            .ram_data_in   (din[g]),
            .ram_ready     (ready[g]),
            .ram_ack       (ack[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: writes land first, a read returns the (possibly just written) word,
    // and the returned word persists until the next read.
    function automatic logic [15:0] model_apply(input int d, input bit r, input bit w,
                                                input logic [5:0] ra, input logic [5:0] wa,
                                                input logic [15:0] wd);
        if (w) mdl_mem[d][wa] = wd;
        if (r) mdl_dout[d] = mdl_mem[d][ra];
        return mdl_dout[d];
    endfunction

    task automatic model_clear(input int d);
        for (int a = 0; a < 64; a++) mdl_mem[d][a] = 16'h0000;
        mdl_dout[d] = 16'h0000;
    endtask

    // Returns at a falling edge with ready high; a timeout counts as a failure.
    task automatic wait_ready(input int d, output int edges);
        edges = 0;
        while (!ready[d] && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        if (!ready[d]) check($sformatf("ready_timeout_dut%0d", d), 32'(ready[d]), 32'd1);
    endtask

    task automatic txn(input int d, input bit r, input bit w, input logic [5:0] ra,
                       input logic [5:0] wa, input logic [15:0] wd, input logic [15:0] exp,
                       input string name);
        int k;
        int dummy;
        wait_ready(d, dummy);
        rd_i[d] = r; wr_i[d] = w; ra_i[d] = ra; wa_i[d] = wa; wd_i[d] = wd;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!ack[d] && k <= ws_of(d)) check({name, "_ready_during_wait"}, 32'(ready[d]), 32'd0);
        end while (!ack[d] && k < 40);
        rd_i[d] = 1'b0; wr_i[d] = 1'b0;
        check({name, "_ack_latency"}, 32'(k), 32'(ws_of(d) + 1));
        check({name, "_data"}, 32'(din[d]), 32'(exp));
        check({name, "_no_overlap"}, 32'(ready[d] & ack[d]), 32'd0);
        @(negedge clk);
        check({name, "_single_ack"}, 32'(ack[d]), 32'd0);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [5:0]  ra;
        logic [5:0]  wa;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int edges;
        int acks;
        logic [15:0] e;

        vecs[0] = '{r:1, w:0, ra:6'd63, wa:6'd0,  wd:16'h0000, exp:16'h0000};
        vecs[1] = '{r:0, w:1, ra:6'd0,  wa:6'd5,  wd:16'hBEEF, exp:16'h0000};
        vecs[2] = '{r:1, w:0, ra:6'd5,  wa:6'd0,  wd:16'h0000, exp:16'hBEEF};
        vecs[3] = '{r:1, w:1, ra:6'd12, wa:6'd12, wd:16'h1234, exp:16'h1234};
        vecs[4] = '{r:1, w:0, ra:6'd12, wa:6'd0,  wd:16'h0000, exp:16'h1234};
        vecs[5] = '{r:0, w:1, ra:6'd0,  wa:6'd3,  wd:16'h00AA, exp:16'h1234};
        vecs[6] = '{r:1, w:1, ra:6'd3,  wa:6'd4,  wd:16'h5555, exp:16'h00AA};
        vecs[7] = '{r:1, w:0, ra:6'd4,  wa:6'd0,  wd:16'h0000, exp:16'h5555};
        vecs[8] = '{r:0, w:1, ra:6'd0,  wa:6'd7,  wd:16'h0F0F, exp:16'h5555};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rd_i[d] = 1'b0; wr_i[d] = 1'b0;
            ra_i[d] = '0; wa_i[d] = '0; wd_i[d] = '0;
            model_clear(d);
        end

        // Reset held for three cycles, then the 64-edge clearing sweep.
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_din_dut%0d", d), 32'(din[d]), 32'd0);
            check($sformatf("reset_ready_dut%0d", d), 32'(ready[d]), 32'd0);
            check($sformatf("reset_ack_dut%0d", d), 32'(ack[d]), 32'd0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        edges = 0;
        while (!ready[0] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack[0]) check("init_ack", 32'(ack[0]), 32'd0);
        end
        check("init_edges", 32'(edges), 32'd64);
        check("init_ready_dut1", 32'(ready[1]), 32'd1);
        check("init_ready_dut2", 32'(ready[2]), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e = model_apply(0, vecs[i].r, vecs[i].w, vecs[i].ra, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d_model", i), 32'(e), 32'(vecs[i].exp));
            txn(0, vecs[i].r, vecs[i].w, vecs[i].ra, vecs[i].wa, vecs[i].wd, vecs[i].exp,
                $sformatf("vec%0d", i));
        end

        // Held read on the zero-wait-state instance: an ack on every other cycle.
        wait_ready(1, edges);
        rd_i[1] = 1'b1; ra_i[1] = 6'd20;
        acks = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("held_ack_c%0d", i), 32'(ack[1]), 32'(i % 2));
            check($sformatf("held_ready_c%0d", i), 32'(ready[1]), 32'((i + 1) % 2));
            if (ack[1]) acks++;
        end
        rd_i[1] = 1'b0;
        check("held_ack_count", 32'(acks), 32'd5);
        check("held_data", 32'(din[1]), 32'h0000);

        // Reset during WAIT aborts a write on the three-wait-state instance.
        e = model_apply(2, 1'b0, 1'b1, 6'd0, 6'd9, 16'h1111);
        txn(2, 1'b0, 1'b1, 6'd0, 6'd9, 16'h1111, e, "pre_abort_write");
        wait_ready(2, edges);
        wr_i[2] = 1'b1; wa_i[2] = 6'd9; wd_i[2] = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_wait", 32'(ready[2] | ack[2]), 32'd0);
        rst[2] = 1'b1;
        wr_i[2] = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        rst[2] = 1'b0;
        model_clear(2);
        edges = 0;
        while (!ready[2] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack[2]) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_init_edges", 32'(edges), 32'd64);
        check("abort_din_cleared", 32'(din[2]), 32'h0000);
        @(negedge clk);
        txn(2, 1'b1, 1'b0, 6'd9, 6'd0, 16'h0000, 16'h0000, "abort_read9");

        // Randomised traffic over a narrow address range to force collisions.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                bit r, w;
                logic [5:0]  ra, wa;
                logic [15:0] wd;
                int kind;
                kind = int'($urandom_range(0, 2));
                r  = (kind != 1);
                w  = (kind != 0);
                ra = 6'($urandom_range(0, 7));
                wa = 6'($urandom_range(0, 7));
                wd = 16'($urandom);
                e  = model_apply(d, r, w, ra, wa, wd);
                txn(d, r, w, ra, wa, wd, e, $sformatf("rand_d%0d_n%0d", d, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end
endmodule
